// File: rtl/ntt_bf_sched.sv
// ntt_bf_sched: stage/address scheduler for a radix-2 add/sub butterfly PE
// working in place on an N-point coefficient RAM.
//
// On start_i it sweeps all LOG_N stages, forward (half-span shrinking) or
// inverse (half-span growing). It issues one butterfly read pair per cycle.
// The addresses are carried through a shift line that matches RAM read
// latency plus PE latency, and they come out as the write-back pair. The
// pipeline is drained between stages, so no stage reads a word before the
// previous stage has written it.
//
// Ports
//   clk_i                    clock, rising edge
//   rst_i                    asynchronous, active-high reset
//   start_i, mode_i          run request and direction (0 fwd, 1 inv)
//   busy_o, done_o           run in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_u/v_o   butterfly operand read pair
//   bf_sel_o                 latched direction, goes to the PE sel input
//   wr_en_o, wr_addr_u/v_o   write-back pair (upper result to u, lower to v)
//   stage_o                  current stage index
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start_i
// S_ISSUE  | one read pair per cycle, j = 0 .. N/2-1
// S_DRAIN  | MEM_LAT+PE_LAT cycles with no reads, pending writes retire
// S_DONE   | done_o pulse, then back to S_IDLE

module ntt_bf_sched #(
  parameter int N       = 256,
  parameter int LOG_N   = 8,
  parameter int ADDR_W  = 8,
  parameter int PE_LAT  = 6,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        rd_addr_u_o,
  output logic [ADDR_W-1:0]        rd_addr_v_o,
  output logic                     bf_sel_o,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_u_o,
  output logic [ADDR_W-1:0]        wr_addr_v_o,
  output logic [$clog2(LOG_N)-1:0] stage_o
);

  localparam int STG_W = $clog2(LOG_N);
  localparam int J_W   = LOG_N - 1;
  localparam int DLY   = MEM_LAT + PE_LAT;
  localparam int CNT_W = $clog2(DLY + 1);

  localparam logic [J_W-1:0]   J_LAST     = J_W'(N / 2 - 1);
  localparam logic [STG_W-1:0] STG_LAST   = STG_W'(LOG_N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DLY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [J_W-1:0]      j_q;
  logic [STG_W-1:0]    stage_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                bf_sel_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_u_q;
  logic [ADDR_W-1:0]   rd_v_q;

  logic                vld_q [DLY];
  logic [ADDR_W-1:0]   au_q  [DLY];
  logic [ADDR_W-1:0]   av_q  [DLY];

  // Next read pair to load: selects which (j, stage, direction) the next
  // issued read belongs to, so the FSM can register the address directly.
  logic [J_W-1:0]      nxt_j_d;
  logic [STG_W-1:0]    nxt_stage_d;
  logic                nxt_mode_d;
  logic [STG_W-1:0]    nxt_p_d;
  logic [ADDR_W-1:0]   nxt_u_d;
  logic [ADDR_W-1:0]   nxt_v_d;

  // Forward sweeps start at the widest span, inverse at span 1.
  function automatic logic [STG_W-1:0] bit_pos(input logic [STG_W-1:0] stg,
                                               input logic             inv);
    return inv ? stg : (STG_LAST - stg);
  endfunction

  // Insert a 0 at bit p of j: bits below p stay, bits at p and up move up.
  function automatic logic [ADDR_W-1:0] addr_u(input logic [J_W-1:0]   j,
                                               input logic [STG_W-1:0] p);
    logic [ADDR_W-1:0] jx;
    logic [ADDR_W-1:0] lo;
    jx = ADDR_W'(j);
    lo = (ADDR_W'(1) << p) - ADDR_W'(1);
    return ((jx & ~lo) << 1) | (jx & lo);
  endfunction

  always_comb begin
    nxt_j_d     = j_q + J_W'(1);
    nxt_stage_d = stage_q;
    nxt_mode_d  = bf_sel_q;
    if (state_q == S_IDLE) begin
      nxt_j_d     = '0;
      nxt_stage_d = '0;
      nxt_mode_d  = mode_i;
    end else if (state_q == S_DRAIN) begin
      nxt_j_d     = '0;
      nxt_stage_d = stage_q + STG_W'(1);
    end
    nxt_p_d = bit_pos(nxt_stage_d, nxt_mode_d);
    nxt_u_d = addr_u(nxt_j_d, nxt_p_d);
    nxt_v_d = nxt_u_d | (ADDR_W'(1) << nxt_p_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      j_q      <= '0;
      stage_q  <= '0;
      cnt_q    <= '0;
      bf_sel_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_u_q   <= '0;
      rd_v_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            bf_sel_q <= mode_i;
            stage_q  <= '0;
            j_q      <= '0;
            busy_q   <= 1'b1;
            rd_en_q  <= 1'b1;
            rd_u_q   <= nxt_u_d;
            rd_v_q   <= nxt_v_d;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (j_q == J_LAST) begin
            rd_en_q <= 1'b0;
            rd_u_q  <= '0;
            rd_v_q  <= '0;
            cnt_q   <= DRAIN_LOAD;
            state_q <= S_DRAIN;
          end else begin
            j_q    <= nxt_j_d;
            rd_u_q <= nxt_u_d;
            rd_v_q <= nxt_v_d;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            if (stage_q == STG_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              stage_q <= nxt_stage_d;
              j_q     <= '0;
              rd_en_q <= 1'b1;
              rd_u_q  <= nxt_u_d;
              rd_v_q  <= nxt_v_d;
              state_q <= S_ISSUE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read-to-write delay line. Reset flushes it, dropping in-flight writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DLY; i++) begin
        vld_q[i] <= 1'b0;
        au_q[i]  <= '0;
        av_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= rd_en_q;
      au_q[0]  <= rd_u_q;
      av_q[0]  <= rd_v_q;
      for (int i = 1; i < DLY; i++) begin
        vld_q[i] <= vld_q[i-1];
        au_q[i]  <= au_q[i-1];
        av_q[i]  <= av_q[i-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_u_o = rd_u_q;
  assign rd_addr_v_o = rd_v_q;
  assign bf_sel_o    = bf_sel_q;
  assign stage_o     = stage_q;
  assign wr_en_o     = vld_q[DLY-1];
  assign wr_addr_u_o = au_q[DLY-1];
  assign wr_addr_v_o = av_q[DLY-1];

endmodule

// File: doc/ntt_bf_sched.md
# ntt_bf_sched

Stage/address scheduler for the 12-bit add/sub butterfly PE (6-cycle register latency) over an N-point coefficient memory with 1-cycle read latency. On `start` it sweeps all log2(N) radix-2 stages in either forward (CT, half-span shrinking) or inverse (GS, half-span growing) order. Each cycle it issues one butterfly read pair, delays the addresses to match memory plus PE latency, and issues the matching write-back. It drains the pipeline between stages to avoid read-after-write hazards. It sits between the top-level NTT control and the coefficient RAM/PE pair.

## Interface
- `N`, 256, transform size (power of two, ≥4)
- `LOG_N`, 8, log2(N)
- `ADDR_W`, 8, coefficient address width (= LOG_N)
- `PE_LAT`, 6, butterfly register latency, input to output
- `MEM_LAT`, 1, RAM read latency
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request, honoured only in IDLE
- `mode`  in  1  0 = forward, 1 = inverse; sampled with `start`
- `busy`  out  1  high from the first ISSUE cycle through the last write
- `done`  out  1  one-cycle pulse after the last write
- `rd_en`  out  1  read strobe for both banks/ports
- `rd_addr_u`, `rd_addr_v`  out  ADDR_W  butterfly operand addresses
- `bf_sel`  out  1  latched `mode`, held for the whole run, to PE `sel`
- `wr_en`  out  1  write-back strobe
- `wr_addr_u`, `wr_addr_v`  out  ADDR_W  write addresses for PE `bf_upper` / `bf_lower`
- `stage`  out  $clog2(LOG_N)  current stage index (debug/twiddle lookup)

## Operation
- FSM states:
  - IDLE: `start` latches `mode` into `bf_sel`, clears `stage` and `j`, and moves to ISSUE. `start` in any other state is ignored.
  - ISSUE: `rd_en`=1 and `j` increments every cycle. When `j`=N/2−1, go to DRAIN.
  - DRAIN: waits `MEM_LAT+PE_LAT` (7) cycles with `rd_en`=0. At the end, if `stage`=LOG_N−1 go to DONE; otherwise increment `stage`, clear `j`, and return to ISSUE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Butterfly index `j` is LOG_N−1 bits, range 0..N/2−1.
- Bit position p: forward uses p = LOG_N−1−stage; inverse uses p = stage.
- Address generation:
  - `rd_addr_u` = `j` with a 0 inserted at bit p. Bits below p are unchanged; bits at p and above shift up by one.
  - `rd_addr_v` = `rd_addr_u` | (1<<p), i.e. half-span 2^p.
- Write path:
  - A valid/address shift line of depth `MEM_LAT+PE_LAT` carries `rd_en`, `rd_addr_u` and `rd_addr_v`.
  - Its outputs drive `wr_en`, `wr_addr_u` and `wr_addr_v`.
  - Results are written in place: upper result to u, lower to v.
- Reset (any time, including mid-run):
  - FSM returns to IDLE.
  - The shift line is cleared, so in-flight writes are dropped.
  - All outputs go to 0: `busy`, `done`, `rd_en`, `wr_en`, all addresses, `bf_sel`, `stage`.
- Every address is written exactly once per stage. No address is read in stage s+1 before its stage-s write has completed.

## Timing
- Cycle 0: `start` sampled in IDLE. Cycle 1: first ISSUE cycle, `busy` rises.
- Stage k (0-based):
  - Reads in cycles 1+135k .. 128+135k.
  - Writes in cycles 8+135k .. 135+135k.
  - DRAIN occupies cycles 129+135k .. 135+135k.
  - Stage period = N/2+MEM_LAT+PE_LAT = 135 cycles.
- Read-to-write latency is exactly 7 cycles per butterfly, and `wr_en` is contiguous per stage.
- Last write is at cycle 1080. `busy` falls and `done`=1 in cycle 1081. IDLE in cycle 1082, where a new `start` is accepted.
- Read and write addresses never coincide within a cycle, so a dual-port RAM is sufficient.

## Test plan
- Reset then idle: hold `rst`=1 for 3 cycles, then release with `start`=0 for 20 cycles. All outputs stay 0.
- Forward sweep:
  - `start`,`mode`=0 at cycle 0.
  - Cycle 1: `rd_addr_u`=0, `rd_addr_v`=128. Cycle 2: 1/129. Cycle 128: 127/255.
  - Stage 1, first cycle (136): 0/64. Stage 7: pairs (0,1),(2,3)…
  - `done` exactly at cycle 1081; 1024 total `wr_en` cycles.
- Inverse sweep, `mode`=1:
  - Stage 0 pairs (0,1),(2,3)…; stage 7 pairs (0,128),(1,129)…
  - `bf_sel`=1 from cycle 1 until IDLE.
- Latency/hazard check:
  - Every `wr_addr` pair equals the `rd_addr` pair from 7 cycles earlier.
  - No read of an address that has a pending write in the shift line. A scoreboard against a software in-place NTT using the PE model matches all 256 words.
- Start while busy: pulse `start` at cycles 50 and 1081. No restart and identical timing. A `start` at 1082 begins a new run with its first read at cycle 1083.
- Reset mid-run: assert `rst` at cycle 300, the 30th read of stage 2.
  - `wr_en` drops immediately and no further writes occur.
  - After release, `start` yields a fresh run from stage 0, `j`=0.
